// File: rtl/gated_mux_pipe.sv
// Select one of NUM_INPUTS words, AND it with a gate word, and carry the result
// through an elastic valid/ready pipeline of STAGES registers.
module gated_mux_pipe #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4,
  parameter int STAGES     = 2,
  parameter int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_INPUTS*WIDTH-1:0] i_i,
  input  logic [SEL_W-1:0]            s_i,
  input  logic [WIDTH-1:0]            b_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        flush_i,
  output logic [WIDTH-1:0]            y_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  logic [WIDTH-1:0]  w_word;
  logic [WIDTH-1:0]  w_result;
  logic [STAGES:0]   w_adv;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [STAGES-1:0] r_valid;

  // Out-of-range selects match no word and yield zero; invalid transfers also
  // load zero so an empty stage always carries a cleared word.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (s_i == SEL_W'(k)) begin
        w_word = i_i[k*WIDTH +: WIDTH];
      end
    end
    w_result = b_i & w_word & {WIDTH{valid_i}};
  end

  always_comb begin : advChain
    logic acc;
    w_adv         = '0;
    acc           = ready_i;
    w_adv[STAGES] = ready_i;
    for (int n = STAGES - 1; n >= 0; n--) begin
      acc      = acc | ~r_valid[n];
      w_adv[n] = acc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int n = 0; n < STAGES; n++) begin
        r_data[n] <= '0;
      end
      r_valid <= '0;
    end else begin
      if (w_adv[0]) begin
        r_data[0]  <= w_result;
        r_valid[0] <= valid_i;
      end
      for (int n = 1; n < STAGES; n++) begin
        if (w_adv[n]) begin
          r_data[n]  <= r_data[n-1];
          r_valid[n] <= r_valid[n-1];
        end
      end
    end
  end

  assign ready_o = w_adv[0] & ~flush_i;
  assign y_o     = r_data[STAGES-1];
  assign valid_o = r_valid[STAGES-1];

endmodule

// File: doc/gated_mux_pipe.md
Name: gated_mux_pipe

Overview:
Parametrised successor to the 2:1 mux + AND merged cell. Selects one of NUM_INPUTS words, ANDs it bitwise with a gate word, and carries the result through an elastic valid/ready pipeline of STAGES registers. It sits between register-file read ports and datapath consumers in the 74-series CPU flow. Each stage maps onto the library's MUX/AND/DFF cells.

Parameters:
WIDTH, 8, data word width in bits (>=1)
NUM_INPUTS, 4, number of selectable input words (>=2)
STAGES, 2, pipeline register stages (1..4)
SEL_W, max(1,$clog2(NUM_INPUTS)), select width; derived, not to be overridden

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
i_i  input  NUM_INPUTS*WIDTH  packed input words; word k = i_i[k*WIDTH +: WIDTH]
s_i  input  SEL_W  binary select
b_i  input  WIDTH  bitwise gate word
valid_i  input  1  upstream transfer valid
ready_o  output  1  block can accept a transfer this cycle
flush_i  input  1  discard all in-flight transfers
y_o  output  WIDTH  result of the oldest in-flight transfer
valid_o  output  1  y_o is valid
ready_i  input  1  downstream accepts y_o

Behaviour:
- Clock is clk_i. Reset is rst_i: synchronous and active-high. It has priority over every other input.
- Function: result = b_i & word[s_i]. If s_i >= NUM_INPUTS, result = 0.
- Stage n holds data_n[WIDTH] and v_n. Stage 0 captures the input. Stage STAGES-1 drives y_o = data and valid_o = v directly from flops, with no combinational path from the inputs.
- Input transfer occurs when valid_i & ready_o. Output transfer occurs when valid_o & ready_i.
- Stage n may load when it is empty, or when it is emptying this cycle:
  - adv_n = !v_n | adv_(n+1)
  - adv_STAGES = ready_i
- ready_o = adv_0 & !flush_i. The combinational path ready_i -> ready_o is permitted.
- When adv_(n+1) is high, stage n+1 loads data_n and v_n.
- Stage 0 loads the computed result and valid_i when adv_0 is high.
- A stage whose adv is low holds its data and valid unchanged. y_o is therefore stable while valid_o & !ready_i.
- Latency: exactly STAGES cycles from input transfer to valid_o when ready_i is held high. Throughput is 1 transfer per cycle. No bubbles are inserted.
- Backpressure: with ready_i low, the pipe fills. After STAGES accepted transfers ready_o goes low. When ready_i rises, ready_o goes high in the same cycle.
- Data in an invalid stage is don't-care internally. y_o must still read 0 whenever valid_o is 0 after reset or flush; all data regs clear on reset and on flush.
- Reset values: y_o = 0, valid_o = 0, all v_n = 0. ready_o = 1 once rst_i is low (combinational from the empty pipe).
- Flush (flush_i high, rst_i low):
  - next cycle all v_n = 0 and all data_n = 0;
  - ready_o = 0 during the flush cycle; an input presented in that cycle is not accepted;
  - an output handshake in the flush cycle still counts as completed for downstream.
- Reset or flush mid-stream: all in-flight transfers are lost. No partial or stale output may appear afterwards.
- Simultaneous input and output transfer on a full pipe: allowed, occupancy unchanged.
- Inputs i_i, s_i and b_i are sampled only on an accepted input transfer.

Test Plan:
1. Reset/idle: WIDTH=8, NUM_INPUTS=4, STAGES=2. Assert rst_i for 2 cycles, then release -> y_o=0x00, valid_o=0, ready_o=1.
2. Basic latency: i_i words {0x11,0x22,0x33,0x44}, s_i=2, b_i=0xF0, valid_i for 1 cycle, ready_i=1 -> valid_o high exactly 2 cycles later with y_o=0x30, for 1 cycle.
3. Streaming: 16 back-to-back transfers with s_i cycling 0..3, b_i=0xFF, ready_i=1 -> 16 consecutive valid_o cycles, data in order, ready_o never low.
4. Backpressure: ready_i=0 while 3 transfers are offered -> first 2 accepted, then ready_o=0 and y_o holds the first result. Raise ready_i -> ready_o=1 the same cycle and all 3 results delivered in order, none duplicated.
5. Out-of-range select: NUM_INPUTS=3, s_i=3, b_i=0xFF -> y_o=0x00 with valid_o=1.
6. Flush and reset mid-stream: with 2 transfers in flight, pulse flush_i for 1 cycle while valid_i=1 -> ready_o=0 that cycle, valid_o=0 next cycle, and the flushed and offered data never appear. Repeat with rst_i -> same result.
